// File: rtl/cbuf_write_arbiter.sv
// Circular-buffer control with a 4-way round-robin write arbiter.
// Tracks write/read pointers and occupancy; flags sticky overflow/underflow.
module cbuf_write_arbiter #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr_req,
    output logic [3:0]        wr_grant,
    input  logic              read_en,
    output logic              ready,
    output logic              valid,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        rr_q, rr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic       hit;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       do_write;
    logic       do_read;

    // Status comes only from the registered count; no same-cycle bypass.
    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);
    assign ready = ~full;
    assign valid = ~empty;

    // First requester found searching rr, rr+1, rr+2, rr+3 (mod 4).
    always_comb begin
        hit      = 1'b0;
        pick_idx = rr_q;
        cand     = rr_q;
        for (int j = 0; j < 4; j++) begin
            cand = rr_q + 2'(j);
            if (!hit && wr_req[cand]) begin
                hit      = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign do_write = hit && ready && !rst;
    assign do_read  = read_en && valid && !rst;

    always_comb begin
        wr_grant = 4'b0000;
        if (do_write) begin
            wr_grant = 4'b0001 << pick_idx;
        end
    end

    assign wen = do_write;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rr_d    = rr_q;
        ovf_d   = ovf_q | ((|wr_req) && full);
        udf_d   = udf_q | (read_en && empty);
        if (do_write) begin
            wptr_d = wptr_q + 1'b1;
            rr_d   = pick_idx + 2'd1;
        end
        if (do_read) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({do_write, do_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign waddr = wptr_q;
    assign raddr = rptr_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_cbuf_write_arbiter.sv
// Randomized bench for cbuf_write_arbiter against a cycle-level occupancy model,
// with directed scenarios pinned by hand-computed literals.
module tb_cbuf_write_arbiter;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        wr_req;
    logic [3:0]        wr_grant;
    logic              read_en;
    logic              ready, valid, wen, full, empty, ovf, udf;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [ADDR_W:0]   count;

    cbuf_write_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_grant(wr_grant), .read_en(read_en),
        .ready(ready), .valid(valid), .wen(wen), .waddr(waddr), .raddr(raddr),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: plain integers.
    int m_cnt = 0, m_w = 0, m_r = 0, m_rr = 0;
    bit m_ovf = 0, m_udf = 0;
    bit m_known = 0;
    logic [3:0] g_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare mid-cycle, update model at posedge.
    task automatic cyc(input logic r, input logic [3:0] q, input logic re);
        int gi;
        bit wr, rd;
        logic [3:0] eg;
        logic [20:0] exp_v, act_v;
        @(negedge clk);
        rst = r; wr_req = q; read_en = re;
        #1;
        gi = -1;
        for (int j = 0; j < 4; j++) begin
            if (gi < 0 && q[(m_rr + j) % 4]) gi = (m_rr + j) % 4;
        end
        wr = !r && gi >= 0 && m_cnt < DEPTH;
        rd = !r && re && m_cnt > 0;
        eg = wr ? 4'(1 << gi) : 4'b0000;
        g_seen = wr_grant;
        if (m_known) begin
            exp_v = {eg, wr, 3'(m_w), 3'(m_r), 4'(m_cnt), m_cnt == DEPTH, m_cnt == 0,
                     m_cnt != DEPTH, m_cnt != 0, m_ovf, m_udf};
            act_v = {wr_grant, wen, waddr, raddr, count, full, empty, ready, valid, ovf, udf};
            chk("model", 32'(act_v), 32'(exp_v));
        end
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_w = 0; m_r = 0; m_rr = 0; m_ovf = 0; m_udf = 0; m_known = 1;
        end else begin
            m_ovf = m_ovf | (q != 0 && m_cnt == DEPTH);
            m_udf = m_udf | (re && m_cnt == 0);
            if (wr) begin m_w = (m_w + 1) % DEPTH; m_rr = (gi + 1) % 4; end
            if (rd) m_r = (m_r + 1) % DEPTH;
            m_cnt = m_cnt + int'(wr) - int'(rd);
        end
        #1;
    endtask

    logic [3:0] exp_g [4];

    initial begin
        rst = 1'b1; wr_req = 4'b0; read_en = 1'b0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;

        cyc(1, 4'b1111, 1);
        cyc(1, 4'b0000, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_flags", {28'b0, empty, full, ready, valid}, 32'b1010);
        chk("rst_ptrs", {26'b0, waddr, raddr}, 0);

        // Fairness
        for (int i = 0; i < 4; i++) begin
            chk("fair_waddr", 32'(waddr), 32'(i));
            cyc(0, 4'b1111, 0);
            chk("fair_grant", 32'(g_seen), 32'(exp_g[i]));
        end
        chk("fair_count", 32'(count), 4);

        // Skip idle requesters
        cyc(0, 4'b1010, 0);
        chk("skip_g0", 32'(g_seen), 32'b0010);
        cyc(0, 4'b1010, 0);
        chk("skip_g1", 32'(g_seen), 32'b1000);
        cyc(0, 4'b0000, 1);
        cyc(0, 4'b0000, 1);
        chk("skip_count", 32'(count), 4);

        // Simultaneous access and wrap: wptr 6 -> 0, rptr 2 -> 4
        for (int i = 0; i < 10; i++) cyc(0, 4'b0100, 1);
        chk("wrap_count", 32'(count), 4);
        chk("wrap_waddr", 32'(waddr), 0);
        chk("wrap_raddr", 32'(raddr), 4);

        // Fill and overflow
        cyc(1, 4'b0000, 0);
        for (int i = 0; i < 8; i++) cyc(0, 4'b0001, 0);
        chk("fill_full", {30'b0, full, ready}, 32'b10);
        chk("fill_count", 32'(count), 8);
        cyc(0, 4'b0100, 0);
        chk("ovf_grant", 32'(g_seen), 0);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(ovf), 1);

        // Full-plus-read stall
        cyc(0, 4'b0001, 1);
        chk("stall_grant", 32'(g_seen), 0);
        chk("stall_count", 32'(count), 7);
        cyc(0, 4'b0001, 0);
        chk("after_grant", 32'(g_seen), 32'b0001);
        chk("after_count", 32'(count), 8);

        // Underflow and mid-run reset
        cyc(1, 4'b0000, 0);
        cyc(0, 4'b0000, 1);
        chk("udf_flag", 32'(udf), 1);
        chk("udf_raddr", 32'(raddr), 0);
        for (int i = 0; i < 5; i++) cyc(0, 4'b1111, 0);
        chk("pre_rst_count", 32'(count), 5);
        cyc(1, 4'b1111, 1);
        chk("rst_grant", 32'(g_seen), 0);
        chk("midrst_state", {26'b0, count, udf, empty}, 32'b000001);
        cyc(0, 4'b1111, 0);
        chk("post_rst_grant", 32'(g_seen), 32'b0001);

        // Randomized run; read bias drifts so the buffer visits full and empty.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2 == 0) ? 3 : 12;
            cyc(($urandom_range(0, 99) == 0), 4'($urandom),
                ($urandom_range(0, 15) < bias));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cbuf_write_arbiter.md
CBUF_WRITE_ARBITER -- requirements
Module: cbuf_write_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 3, as the buffer address width; DEPTH = 2**ADDR_W.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- wr_req  input  4  per-requester write request; bit i = requester i
- wr_grant  output  4  one-hot write grant, combinational, this cycle
- read_en  input  1  consumer read request
- ready  output  1  buffer can accept a write; = ~full
- valid  output  1  buffer holds readable data; = ~empty
- wen  output  1  buffer write strobe; = |wr_grant
- waddr  output  ADDR_W  buffer write address; = write pointer
- raddr  output  ADDR_W  buffer read address; = read pointer
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- ovf  output  1  sticky: |wr_req seen while full
- udf  output  1  sticky: read_en seen while empty

Function
REQ-003 A write SHALL occur in a cycle iff |wr_req && ready.
- In that cycle exactly one wr_grant bit is high and wen = 1.
- Otherwise wr_grant = 0 and wen = 0.
REQ-004 Arbitration SHALL be round-robin using a 2-bit priority pointer rr.
- The grant goes to the first requesting index searched rr, rr+1, rr+2, rr+3, modulo 4.
REQ-005 On each write, rr SHALL load (granted index + 1) mod 4.
- rr is unchanged in cycles with no write.
REQ-006 A read SHALL occur iff read_en && valid.
- Data is taken from raddr in that cycle; the read pointer advances at the clock edge.
REQ-007 The write pointer SHALL increment by 1 per write, and the read pointer by 1 per read.
- Both wrap from DEPTH-1 to 0 by natural ADDR_W-bit overflow.
REQ-008 Count SHALL update at the edge as follows:
- +1 on write only;
- -1 on read only;
- unchanged on simultaneous write and read, or on neither.
REQ-009 full, empty, ready and valid SHALL derive only from registered count.
- There is no same-cycle bypass: when full, a write stalls even if a read occurs in the same cycle.
- When empty, a read stalls even if a write occurs in the same cycle.
REQ-010 Stalled requesters SHALL keep wr_req asserted.
- The block does not queue requests; a requester knows it was accepted only from its wr_grant bit.
REQ-011 ovf SHALL set when |wr_req && full, and udf SHALL set when read_en && empty.
- Both hold until reset.
- The offending access is dropped with no pointer, count or rr change.
REQ-012 The block SHALL never let count exceed DEPTH or fall below 0, and SHALL never assert more than one wr_grant bit.

Reset
REQ-013 While rst = 1 at a rising edge, the block SHALL clear the write pointer, read pointer, count, rr, ovf and udf to 0.
- After that edge: empty = 1, full = 0, ready = 1, valid = 0, waddr = raddr = 0, count = 0.
REQ-014 While rst is high, wr_grant, wen and read effects SHALL be suppressed.
- Reset asserted mid-operation discards all occupancy; requesters still asserting wr_req get no grant until the cycle after rst falls.

Verification
REQ-015 The bench SHALL cover these scenarios:
- Fairness: reset, then wr_req = 4'b1111 for 4 cycles with no reads -> grants 0001, 0010, 0100, 1000; waddr 0,1,2,3; count 4.
- Skip idle requesters: rr = 0, wr_req = 4'b1010 for 2 cycles -> grants 0010 then 1000; rr ends at 0.
- Fill and overflow (ADDR_W = 3): 8 writes -> full = 1, ready = 0. A 9th request -> wr_grant = 0, count stays 8, ovf = 1.
- Simultaneous access and wrap: count = 4, write and read together for 10 cycles -> count stays 4; both pointers wrap 7 -> 0.
- Full-plus-read stall: full, read_en = 1 and wr_req = 1 in the same cycle -> read only; count 7 next cycle; write granted the following cycle.
- Underflow and mid-run reset: read_en = 1 when empty -> udf = 1, raddr unchanged. rst pulsed at count = 5 -> next cycle count = 0, udf = 0, empty = 1.
